inst_fetch_unit: RTL and testbench

Instruction fetch unit for the single-cycle/multicycle datapath: it owns the fetch program counter, issues word reads to instruction memory over a valid/ready request channel, and delivers each fetched instruction with its address to decode over a valid/ready channel. It is the consumer side of the PC: it advances the address by 4 and accepts branch/jump redirects from execute. At most one memory request is outstanding at any time.

---
 rtl/inst_fetch_unit.sv | 124 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Fetch PC owner: one outstanding imem read, 3-cycle best case, holds the instruction until decode takes it.
// Build option FETCH_ALIGN_CHECK_EN: a misaligned redirect enters a sticky FAULT state instead of being truncated.
module inst_fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req_valid,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_rsp_valid,
   input  logic [DATA_W-1:0] imem_rsp_data,
   output logic              inst_valid,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_ready,
   output logic              fault
);

`ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic [2:0] {ST_REQ, ST_WAIT, ST_HOLD, ST_DRAIN, ST_FAULT} state_t;
   logic fault_set;
`else
   typedef enum logic [2:0] {ST_REQ, ST_WAIT, ST_HOLD, ST_DRAIN} state_t;
`endif

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
   logic [ADDR_W-1:0] redir_pc;
   logic              capture;

   assign redir_pc = redirect_pc & ~ADDR_W'(3);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_REQ;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      capture      = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_set    = 1'b0;
`endif
      case (state)
         ST_REQ: begin
            if (redirect_valid) begin
               fetch_pc_nxt = redir_pc;
               state_nxt    = imem_req_ready ? ST_DRAIN : ST_REQ;
            end else if (imem_req_ready) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               fetch_pc_nxt = redir_pc;
               state_nxt    = imem_rsp_valid ? ST_REQ : ST_DRAIN;
            end else if (imem_rsp_valid) begin
               capture      = 1'b1;
               fetch_pc_nxt = fetch_pc + ADDR_W'(4);
               state_nxt    = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               fetch_pc_nxt = redir_pc;
               state_nxt    = ST_REQ;
            end else if (inst_ready) begin
               state_nxt = ST_REQ;
            end
         end
         ST_DRAIN: begin
            // The squashed response still has to be swallowed before a new request goes out.
            if (redirect_valid) fetch_pc_nxt = redir_pc;
            if (imem_rsp_valid) state_nxt = ST_REQ;
         end
`ifdef FETCH_ALIGN_CHECK_EN
         ST_FAULT: ;
`endif
         default: state_nxt = ST_REQ;
      endcase
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_valid && (redirect_pc[1:0] != 2'b00) && (state != ST_FAULT)) begin
         state_nxt    = ST_FAULT;
         fetch_pc_nxt = fetch_pc;
         capture      = 1'b0;
         fault_set    = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc  <= RESET_PC;
         inst_data <= '0;
         inst_pc   <= '0;
      end else begin
         fetch_pc <= fetch_pc_nxt;
         if (capture) begin
            inst_data <= imem_rsp_data;
            inst_pc   <= fetch_pc;
         end
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst)            fault <= 1'b0;
      else if (fault_set) fault <= 1'b1;
   end
`else
   assign fault = 1'b0;
`endif

   assign imem_req_valid = (state == ST_REQ);
   assign imem_req_addr  = fetch_pc;
   assign inst_valid     = (state == ST_HOLD);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: random memory/decode/redirect traffic against an instruction-stream model.
module tb_inst_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;
   logic        fault;

   always #5 clk = ~clk;

   inst_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
      .fault(fault)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, obs, want, $time);
      end
   endtask

   // Memory contents are a fixed hash of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   bit          pend = 0;
   logic [31:0] pend_addr = '0;
   int          pend_cnt = 0;
   bit          use_ovr = 0;
   logic [31:0] ovr_data = '0;
   int          rdy_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;
   logic [31:0] exp_pc = RST_PC;
   int          n_xfer = 0;

   // One clock: drive memory side, score handshakes, advance to the next falling edge.
   task automatic cycle();
      logic        fire;
      logic [31:0] fire_addr;
      imem_rsp_valid = pend && (pend_cnt == 0);
      imem_rsp_data  = imem_rsp_valid ? (use_ovr ? ovr_data : mem_word(pend_addr)) : $urandom();
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      fire      = imem_req_valid && imem_req_ready;
      fire_addr = imem_req_addr;
      if (inst_valid && inst_ready) begin
         chk("inst_pc", inst_pc, exp_pc);
         chk("inst_data", inst_data, mem_word(exp_pc));
         exp_pc = exp_pc + 32'd4;
         n_xfer++;
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
      if (fire) chk("one_outstanding", {31'd0, pend}, 32'd0);
      @(posedge clk);
      if (imem_rsp_valid) begin
         pend    = 0;
         use_ovr = 0;
      end else if (pend) begin
         pend_cnt--;
      end
      if (fire) begin
         pend      = 1;
         pend_addr = fire_addr;
         pend_cnt  = $urandom_range(lat_max, lat_min) - 1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
      @(posedge clk);
      pend    = 0;
      use_ovr = 0;
      @(negedge clk);
      rst    = 1'b0;
      exp_pc = RST_PC;
   endtask

   task automatic run_until_inst(input string tag);
      int n = 0;
      while (!inst_valid && n < 30) begin
         cycle();
         n++;
      end
      chk(tag, {31'd0, inst_valid}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [8:0]  pulses;
      logic [31:0] h_pc, h_dat;
      int          n, x0;

      @(negedge clk);
      do_reset();
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("rst_req_addr", imem_req_addr, RST_PC);
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst_data", inst_data, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);

      // Best-case streaming: one instruction every third cycle.
      inst_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         pulses[i] = inst_valid;
         cycle();
      end
      chk("thru_pattern", {23'd0, pulses}, 32'h124);
      chk("thru_count", n_xfer, 3);

      // Decode stalls with an instruction held.
      inst_ready = 1'b0;
      run_until_inst("hold_reach");
      chk("hold_pc_val", inst_pc, 32'h10C);
      h_pc  = inst_pc;
      h_dat = inst_data;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("hold_valid", {31'd0, inst_valid}, 32'd1);
         chk("hold_pc", inst_pc, h_pc);
         chk("hold_dat", inst_data, h_dat);
         chk("hold_noreq", {31'd0, imem_req_valid}, 32'd0);
      end
      inst_ready = 1'b1;
      cycle();

      // Redirect while waiting; the late response is poisoned and must never reach decode.
      lat_min = 3; lat_max = 3;
      use_ovr = 1; ovr_data = 32'hDEAD_BEEF;
      chk("redir_in_req", {31'd0, imem_req_valid}, 32'd1);
      cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h400;
      cycle();
      redirect_valid = 1'b0;
      n = 0;
      while (!imem_req_valid && n < 10) begin
         chk("drain_no_inst", {31'd0, inst_valid}, 32'd0);
         cycle();
         n++;
      end
      chk("redir_req_seen", {31'd0, imem_req_valid}, 32'd1);
      chk("redir_addr", imem_req_addr, 32'h400);
      lat_min = 1; lat_max = 1;
      run_until_inst("redir_inst");
      chk("redir_inst_pc", inst_pc, 32'h400);
      cycle();

      // Address wrap at the top of the space.
      rdy_pct = 0;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      cycle();
      redirect_valid = 1'b0;
      chk("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      rdy_pct = 100;
      run_until_inst("wrap_inst");
      chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
      cycle();
      chk("wrap_next_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("wrap_next_addr", imem_req_addr, 32'h0);

      // Misaligned redirect.
      rdy_pct = 0;
      redirect_valid = 1'b1; redirect_pc = 32'h202;
      cycle();
      redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis_fault", {31'd0, fault}, 32'd1);
      chk("mis_noreq", {31'd0, imem_req_valid}, 32'd0);
      chk("mis_noinst", {31'd0, inst_valid}, 32'd0);
      rdy_pct = 100;
      for (int i = 0; i < 4; i++) begin
         redirect_valid = 1'b1; redirect_pc = 32'h300;
         cycle();
         chk("mis_sticky", {31'd0, fault}, 32'd1);
         chk("mis_stuck", {31'd0, imem_req_valid}, 32'd0);
      end
      redirect_valid = 1'b0;
`else
      chk("mis_fault", {31'd0, fault}, 32'd0);
      chk("mis_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("mis_addr", imem_req_addr, 32'h200);
      rdy_pct = 100;
      run_until_inst("mis_inst");
      chk("mis_inst_pc", inst_pc, 32'h200);
      cycle();
`endif
      do_reset();

      // Reset while draining a squashed request.
      rdy_pct = 100; lat_min = 4; lat_max = 4;
      redirect_valid = 1'b1; redirect_pc = 32'h800;
      cycle();
      redirect_valid = 1'b0;
      chk("drain_noreq", {31'd0, imem_req_valid}, 32'd0);
      chk("drain_noinst", {31'd0, inst_valid}, 32'd0);
      cycle();
      do_reset();
      chk("drst_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("drst_req_addr", imem_req_addr, RST_PC);
      chk("drst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("drst_fault", {31'd0, fault}, 32'd0);
      lat_min = 1; lat_max = 1;
      run_until_inst("drst_inst");
      chk("drst_inst_pc", inst_pc, RST_PC);

      // Random traffic against the stream model.
      x0 = n_xfer;
      rdy_pct = 60; lat_min = 1; lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         inst_ready     = ($urandom_range(99) < 70);
         redirect_valid = ($urandom_range(99) < 4);
         if ($urandom_range(3) == 0)
            redirect_pc = 32'hFFFF_FFF0 + (32'($urandom_range(3)) << 2);
         else
            redirect_pc = 32'($urandom_range(1023)) << 2;
         cycle();
      end
      redirect_valid = 1'b0;
      chk("rand_progress", {31'd0, (n_xfer - x0) > 100}, 32'd1);
      chk("rand_fault", {31'd0, fault}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
